step_source_ctrl: RTL
=====================

STEP_SOURCE_CTRL -- requirements
Module: step_source_ctrl

Interface
REQ-001 SHALL have parameter BURST_W, default 8, burst length counter width.
REQ-002 SHALL have parameter CNT_W, default 16, step counter width.
REQ-003 SHALL have port clk  input  1  single system clock, all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_db  input  1  debounced manual step button, level.
REQ-006 SHALL have port tick  input  1  clock-divider strobe, one clk cycle wide.
REQ-007 SHALL have port auto_req  input  1  trigger level requesting automatic stepping.
REQ-008 SHALL have port burst_len  input  BURST_W  auto steps per burst; 0 means unlimited.
REQ-009 SHALL have port step  output  1  registered one-cycle step pulse to the game datapath.
REQ-010 SHALL have port mode_auto  output  1  high while in AUTO.
REQ-011 SHALL have port busy  output  1  high in ARM, AUTO or DISARM.
REQ-012 SHALL have port burst_done  output  1  one-cycle pulse on burst completion.
REQ-013 SHALL have port step_count  output  CNT_W  total steps emitted, wrapping.

Function
REQ-014 SHALL implement FSM states MANUAL, ARM, AUTO, DISARM.
REQ-015 MANUAL: btn_db rising edge (btn_db=1, prior sample 0) SHALL produce step; auto_req=1 SHALL go to ARM.
REQ-016 MANUAL with edge and auto_req=1 in the same cycle SHALL emit the manual step and still go to ARM.
REQ-017 ARM: first tick SHALL go to AUTO without emitting a step (alignment tick); auto_req=0 SHALL go to MANUAL; button edges ignored.
REQ-018 AUTO: each tick SHALL produce step and increment the burst counter; button edges ignored.
REQ-019 AUTO: when burst_len!=0 and the step just emitted makes burst count equal burst_len, SHALL pulse burst_done with that step and go to DISARM.
REQ-020 AUTO: auto_req=0 SHALL go to DISARM; if tick coincides, auto_req drop wins and no step is emitted.
REQ-021 DISARM: SHALL go to MANUAL only when auto_req=0 and btn_db=0; no steps emitted.
REQ-022 Burst counter SHALL clear on entering AUTO; burst_len SHALL be sampled on the ARM->AUTO transition and held for the burst.
REQ-023 Latency: step and burst_done SHALL assert on the clk edge following the cycle the qualifying event is present at inputs; exactly one cycle wide.
REQ-024 step_count SHALL increment by 1 with every step pulse, wrapping from all-ones to 0.
REQ-025 mode_auto and busy SHALL be registered, reflecting the current state.
REQ-026 Button edge detector history SHALL update every cycle in every state, so a button held across DISARM->MANUAL yields no step.

Reset
REQ-027 rst SHALL immediately force state MANUAL, step=0, mode_auto=0, busy=0, burst_done=0, step_count=0, burst counter=0, button history=0.
REQ-028 rst asserted mid-burst SHALL abort the burst without burst_done.

Structure
REQ-029 State encodings (MANUAL=0, ARM=1, AUTO=2, DISARM=3) and default widths SHALL live in shared package step_ctrl_pkg.
REQ-030 Rising-edge detection SHALL be a sub-module edge_pulse (clk, rst, in, pulse).

Verification
REQ-031 MANUAL, btn_db 0->1 held 10 cycles -> exactly one step, step_count=1.
REQ-032 auto_req=1, burst_len=3, ticks every 4 cycles -> first tick no step, next 3 ticks give steps, burst_done on 3rd, state DISARM, step_count=3.
REQ-033 burst_len=0, auto_req high for 6 ticks after alignment then low -> 6 steps, no burst_done, MANUAL after btn_db=0.
REQ-034 AUTO, tick and auto_req falling same cycle -> no step, DISARM.
REQ-035 rst pulse mid-burst after 2 steps -> all outputs 0 asynchronously, MANUAL, no burst_done.
REQ-036 step_count preloaded to 0xFFFF by running steps -> next step gives 0x0000.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared state encodings and default widths for the step source controller
package step_ctrl_pkg;

    localparam int DEF_BURST_W = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int STATE_W     = 2;

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_AUTO   = 2'd2;
    localparam logic [1:0] ST_DISARM = 2'd3;

    function automatic logic state_busy(input logic [1:0] st);
        return (st != ST_MANUAL);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector; history register updates every cycle
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 1'b0;
        end else begin
            hist <= in;
        end
    end

    // Combinational so the owning FSM can register the resulting action one edge later.
    assign pulse = in & ~hist;

endmodule

// File: rtl/step_source_ctrl.sv
// rtl/step_source_ctrl.sv - selects manual button steps or tick-driven auto bursts
module step_source_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_db,
    input  logic               tick,
    input  logic               auto_req,
    input  logic [BURST_W-1:0] burst_len,
    output logic               step,
    output logic               mode_auto,
    output logic               busy,
    output logic               burst_done,
    output logic [CNT_W-1:0]   step_count
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_n;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_n;
    logic [BURST_W-1:0] burst_lim;
    logic [BURST_W-1:0] burst_lim_n;
    logic [BURST_W-1:0] burst_cnt_inc;
    logic               step_n;
    logic               done_n;
    logic               btn_rise;

    edge_pulse u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (btn_db),
        .pulse (btn_rise)
    );

    assign burst_cnt_inc = burst_cnt + BURST_W'(1);

    always_comb begin
        state_n     = state;
        burst_cnt_n = burst_cnt;
        burst_lim_n = burst_lim;
        step_n      = 1'b0;
        done_n      = 1'b0;
        case (state)
            ST_MANUAL: begin
                step_n = btn_rise;
                if (auto_req) begin
                    state_n = ST_ARM;
                end
            end
            ST_ARM: begin
                // The first tick only aligns the burst to the divider; it emits nothing.
                if (!auto_req) begin
                    state_n = ST_MANUAL;
                end else if (tick) begin
                    state_n     = ST_AUTO;
                    burst_cnt_n = '0;
                    burst_lim_n = burst_len;
                end
            end
            ST_AUTO: begin
                if (!auto_req) begin
                    state_n = ST_DISARM;
                end else if (tick) begin
                    step_n      = 1'b1;
                    burst_cnt_n = burst_cnt_inc;
                    if ((burst_lim != '0) && (burst_cnt_inc == burst_lim)) begin
                        done_n  = 1'b1;
                        state_n = ST_DISARM;
                    end
                end
            end
            ST_DISARM: begin
                if (!auto_req && !btn_db) begin
                    state_n = ST_MANUAL;
                end
            end
            default: begin
                state_n = ST_MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_MANUAL;
            burst_cnt  <= '0;
            burst_lim  <= '0;
            step       <= 1'b0;
            burst_done <= 1'b0;
            mode_auto  <= 1'b0;
            busy       <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_n;
            burst_cnt  <= burst_cnt_n;
            burst_lim  <= burst_lim_n;
            step       <= step_n;
            burst_done <= done_n;
            mode_auto  <= (state_n == ST_AUTO);
            busy       <= state_busy(state_n);
            if (step_n) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

endmodule
